// File: rtl/dcm_seq_pkg.sv
// dcm_reset_sequencer shared types: FSM state encoding,
// retry counter width and lock glitch-filter depth.
package dcm_seq_pkg;

  typedef enum logic [1:0] {
    RESET     = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int RETRY_W      = 4;
  localparam int GLITCH_DEPTH = 4;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop single-bit synchroniser into fclk,
// synchronous active-high reset to 0.
module bit_sync2 (
  input  logic fclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge fclk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dcm_reset_sequencer.sv
// DCM reset/lock sequencer on fclk; restarts the DCM on timeout or lock loss.
// Optional `LOCK_GLITCH_FILTER_EN: loss needs 4 consecutive unlocked cycles.
module dcm_reset_sequencer
  import dcm_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 256,
  parameter int CNT_W         = 17
) (
  input  logic               fclk,
  input  logic               rst,
  input  logic               dcm_locked,
  output logic               dcm_rst,
  output logic               sys_ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;
  logic             lock_drop;

  bit_sync2 u_lock_sync (
    .fclk (fclk),
    .rst  (rst),
    .d    (dcm_locked),
    .q    (locked_s)
  );

`ifdef LOCK_GLITCH_FILTER_EN
  logic [1:0] glitch;

  assign lock_drop = !locked_s &&
                     (glitch == 2'(GLITCH_DEPTH - 1));

  // Counts consecutive unlocked cycles while lock matters
  always_ff @(posedge fclk) begin
    if (rst || locked_s ||
        !(state == SETTLE || state == RUN))
      glitch <= '0;
    else if (!lock_drop)
      glitch <= glitch + 2'd1;
  end
`else
  assign lock_drop = !locked_s;
`endif

  always_ff @(posedge fclk) begin
    if (rst) begin
      state       <= RESET;
      cnt         <= '0;
      dcm_rst     <= 1'b1;
      sys_ready   <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      lock_lost <= 1'b0;
      unique case (state)
        RESET: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            dcm_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= SETTLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            state   <= RESET;
            cnt     <= '0;
            dcm_rst <= 1'b1;
            if (retry_count != '1)
              retry_count <= retry_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (lock_drop) begin
            state   <= RESET;
            cnt     <= '0;
            dcm_rst <= 1'b1;
            if (retry_count != '1)
              retry_count <= retry_count + 1'b1;
          end else if (!locked_s) begin
            cnt <= cnt;
          end else if (cnt == SET_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (lock_drop) begin
            state     <= RESET;
            cnt       <= '0;
            dcm_rst   <= 1'b1;
            sys_ready <= 1'b0;
            lock_lost <= 1'b1;
            if (retry_count != '1)
              retry_count <= retry_count + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Scoreboard bench for dcm_reset_sequencer (RST 4, timeout 100, settle 16).
// Expectations are queued per scenario and compared at their cycle.
module tb_dcm_reset_sequencer;

  logic       fclk = 1'b0;
  logic       rst = 1'b1;
  logic       dcm_locked = 1'b0;
  logic       dcm_rst;
  logic       sys_ready;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [6:0] obs;

  typedef struct {
    int         cyc;
    string      name;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  dcm_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (100),
    .SETTLE_CYCLES (16),
    .CNT_W         (17)
  ) dut (
    .fclk        (fclk),
    .rst         (rst),
    .dcm_locked  (dcm_locked),
    .dcm_rst     (dcm_rst),
    .sys_ready   (sys_ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  always #5 fclk = ~fclk;

  assign obs = {dcm_rst, sys_ready, lock_lost, retry_count};

  task automatic step();
    @(negedge fclk);
    cyc++;
  endtask

  function automatic void push(int c, string nm, logic dr,
                               logic sr, logic ll, logic [3:0] rc);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.v    = {dr, sr, ll, rc};
    sb.push_back(e);
  endfunction

  function automatic logic [3:0] sat(int k);
    return (k > 15) ? 4'd15 : 4'(k);
  endfunction

  task automatic test_reset();
    int t0 = cyc;
    exp_t e;
    push(t0 + 1,  "rst_hold1",   1, 0, 0, 0);
    push(t0 + 3,  "rst_hold3",   1, 0, 0, 0);
    push(t0 + 6,  "rst_last_hi", 1, 0, 0, 0);
    push(t0 + 7,  "rst_release", 0, 0, 0, 0);
    push(t0 + 31, "pre_ready",   0, 0, 0, 0);
    push(t0 + 32, "ready",       0, 1, 0, 0);
    for (int i = 1; i <= 33; i++) begin
      step();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_run++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %b required %b (rst,rdy,lost,retry)",
                   e.name, cyc, obs, e.v);
        end
      end
      if (i == 3) rst = 1'b0;
      if (i == 13) dcm_locked = 1'b1;
    end
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL reset_expired: %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_lock_loss();
    int t0 = cyc;
    exp_t e;
    push(t0 + 3,  "run_before",  0, 1, 0, 0);
    push(t0 + 4,  "loss_pulse",  1, 0, 1, 1);
    push(t0 + 5,  "loss_single", 1, 0, 0, 1);
    push(t0 + 7,  "loss_rst4",   1, 0, 0, 1);
    push(t0 + 8,  "loss_rstend", 0, 0, 0, 1);
    push(t0 + 24, "relock_pre",  0, 0, 0, 1);
    push(t0 + 25, "relock_rdy",  0, 1, 0, 1);
    for (int i = 1; i <= 26; i++) begin
      step();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_run++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %b required %b (rst,rdy,lost,retry)",
                   e.name, cyc, obs, e.v);
        end
      end
      if (i == 1) dcm_locked = 1'b0;
      if (i == 2) dcm_locked = 1'b1;
    end
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL loss_expired: %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_rst_in_run();
    int t0 = cyc;
    exp_t e;
    push(t0 + 2,  "runrst_now",  1, 0, 0, 0);
    push(t0 + 5,  "runrst_hi4",  1, 0, 0, 0);
    push(t0 + 6,  "runrst_lo",   0, 0, 0, 0);
    push(t0 + 22, "runrst_pre",  0, 0, 0, 0);
    push(t0 + 23, "runrst_rdy",  0, 1, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      step();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_run++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %b required %b (rst,rdy,lost,retry)",
                   e.name, cyc, obs, e.v);
        end
      end
      if (i == 1) rst = 1'b1;
      if (i == 2) rst = 1'b0;
    end
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL runrst_expired: %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_settle_glitch();
    int t0 = cyc;
    exp_t e;
    push(t0 + 2,  "sg_reset",    1, 0, 0, 0);
    push(t0 + 23, "sg_settling", 0, 0, 0, 0);
    push(t0 + 24, "sg_restart",  1, 0, 0, 1);
    push(t0 + 25, "sg_nolost",   1, 0, 0, 1);
    push(t0 + 27, "sg_rst4",     1, 0, 0, 1);
    push(t0 + 28, "sg_rstend",   0, 0, 0, 1);
    push(t0 + 44, "sg_pre",      0, 0, 0, 1);
    push(t0 + 45, "sg_rdy",      0, 1, 0, 1);
    for (int i = 1; i <= 46; i++) begin
      step();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_run++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %b required %b (rst,rdy,lost,retry)",
                   e.name, cyc, obs, e.v);
        end
      end
      if (i == 1) begin
        rst = 1'b1;
        dcm_locked = 1'b0;
      end
      if (i == 2) rst = 1'b0;
      if (i == 8) dcm_locked = 1'b1;
      if (i == 21) dcm_locked = 1'b0;
      if (i == 22) dcm_locked = 1'b1;
    end
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL sg_expired: %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    int t0 = cyc;
    int ek;
    exp_t e;
    push(t0 + 2, "to_reset", 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      ek = t0 + 2 + 104 * k;
      push(ek - 1, $sformatf("to%0d_wait", k), 0, 0, 0, sat(k - 1));
      push(ek,     $sformatf("to%0d_rst",  k), 1, 0, 0, sat(k));
      push(ek + 3, $sformatf("to%0d_hi4",  k), 1, 0, 0, sat(k));
      push(ek + 4, $sformatf("to%0d_lo",   k), 0, 0, 0, sat(k));
    end
    for (int i = 1; i <= 2 + 104 * 16 + 5; i++) begin
      step();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_run++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %b required %b (rst,rdy,lost,retry)",
                   e.name, cyc, obs, e.v);
        end
      end
      if (i == 1) begin
        rst = 1'b1;
        dcm_locked = 1'b0;
      end
      if (i == 2) rst = 1'b0;
    end
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL to_expired: %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

`ifdef LOCK_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    int t0 = cyc;
    exp_t e;
    push(t0 + 23, "gf_run",      0, 1, 0, 0);
    push(t0 + 34, "gf_g3_mid",   0, 1, 0, 0);
    push(t0 + 38, "gf_g3_after", 0, 1, 0, 0);
    push(t0 + 45, "gf_g4_pre",   0, 1, 0, 0);
    push(t0 + 46, "gf_g4_lost",  1, 0, 1, 1);
    push(t0 + 47, "gf_g4_after", 1, 0, 0, 1);
    for (int i = 1; i <= 48; i++) begin
      step();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_run++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %b required %b (rst,rdy,lost,retry)",
                   e.name, cyc, obs, e.v);
        end
      end
      if (i == 1) begin
        rst = 1'b1;
        dcm_locked = 1'b1;
      end
      if (i == 2) rst = 1'b0;
      if (i == 30) dcm_locked = 1'b0;
      if (i == 33) dcm_locked = 1'b1;
      if (i == 40) dcm_locked = 1'b0;
      if (i == 44) dcm_locked = 1'b1;
    end
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL gf_expired: %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef LOCK_GLITCH_FILTER_EN
    test_lock_loss();
`endif
    test_rst_in_run();
`ifndef LOCK_GLITCH_FILTER_EN
    test_settle_glitch();
`endif
    test_timeout();
`ifdef LOCK_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
